adc_sdo_emulator: RTL

Synthesizable emulator of the far end of the ADC serial link: the 8-lane, CNV/SCK-driven SDO source that the acquisition controller reads. It responds to the controller's conversion strobe and serial clock with known per-lane sample patterns. This gives bench and on-board loopback testing of the acquisition → FIFO → DDR3 → PipeOut path without real converters. It runs in the MIG `ui_clk` domain and oversamples the incoming CNV_n/SCK.

---
 rtl/adc_sdo_if.sv | 33 +++
 rtl/adc_sdo_emulator.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/adc_sdo_if.sv
// Pin-level bundle between the acquisition controller and the ADC SDO emulator.
// master = controller side, slave = emulator side.
interface adc_sdo_if #(
  parameter int N_LANES = 8
) ();
  logic               i_enable;
  logic               i_ADC_CNV_n;
  logic               i_ADC_SCK;
  logic [N_LANES-1:0] o_ADC_SDO;
  logic               o_busy;
  logic [31:0]        o_conv_count;
  logic               o_overrun;

  modport master (
    output i_enable,
    output i_ADC_CNV_n,
    output i_ADC_SCK,
    input  o_ADC_SDO,
    input  o_busy,
    input  o_conv_count,
    input  o_overrun
  );

  modport slave (
    input  i_enable,
    input  i_ADC_CNV_n,
    input  i_ADC_SCK,
    output o_ADC_SDO,
    output o_busy,
    output o_conv_count,
    output o_overrun
  );
endinterface

// File: rtl/adc_sdo_emulator.sv
// Emulates an 8-lane CNV/SCK-driven ADC SDO source in the ui_clk domain.
// Define ADC_EMU_PRBS_EN to replace the counter/lane-ID pattern with per-lane PRBS-15.
module adc_sdo_emulator #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int N_LANES      = 8,
  parameter int CONV_CYCLES  = 20
) (
  input  logic       clk,
  input  logic       rst,
  adc_sdo_if.slave   bus
);

  localparam int WCW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam int BCW = $clog2(SAMPLE_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_SHIFT
  } state_t;

  state_t                  r_state;
  state_t                  w_state_n;
  logic [WCW-1:0]          r_wait;
  logic [WCW-1:0]          w_wait_n;
  logic [BCW-1:0]          r_bit;
  logic [BCW-1:0]          w_bit_n;
  logic [N_LANES-1:0]      r_sdo;
  logic [N_LANES-1:0]      w_sdo_n;
  logic [31:0]             r_count;
  logic [31:0]             w_count_n;
  logic                    r_overrun;
  logic                    w_overrun_n;
  logic [SAMPLE_WIDTH-1:0] r_shreg [N_LANES];
  logic [SAMPLE_WIDTH-1:0] w_shreg_n [N_LANES];
  logic                    w_load;

  // [0],[1] synchronize; [2] is the delayed copy for edge detection
  logic [2:0] r_cnv_sync;
  logic [2:0] r_sck_sync;
  logic       r_cnv_fall;
  logic       r_sck_fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnv_sync <= 3'b111;
      r_sck_sync <= 3'b000;
      r_cnv_fall <= 1'b0;
      r_sck_fall <= 1'b0;
    end else begin
      r_cnv_sync <= {r_cnv_sync[1:0], bus.i_ADC_CNV_n};
      r_sck_sync <= {r_sck_sync[1:0], bus.i_ADC_SCK};
      r_cnv_fall <= r_cnv_sync[2] & ~r_cnv_sync[1];
      r_sck_fall <= r_sck_sync[2] & ~r_sck_sync[1];
    end
  end

`ifdef ADC_EMU_PRBS_EN
  logic [14:0] r_lfsr [N_LANES];
  logic [14:0] w_lfsr_n [N_LANES];

  // XNOR form of x^15+x^14+1: lock-up state is all ones, so seeds 1..8 are safe
  function automatic logic [14:0] f_lfsr_step(logic [14:0] s);
    return {s[13:0], ~(s[14] ^ s[13])};
  endfunction

  always_comb begin
    for (int l = 0; l < N_LANES; l++) begin
      w_lfsr_n[l] = r_lfsr[l];
      if (w_load) w_lfsr_n[l] = f_lfsr_step(r_lfsr[l]);
    end
  end

  always_ff @(posedge clk) begin
    for (int l = 0; l < N_LANES; l++) begin
      if (rst) r_lfsr[l] <= 15'(l + 1);
      else     r_lfsr[l] <= w_lfsr_n[l];
    end
  end

  function automatic logic [SAMPLE_WIDTH-1:0] f_sample(int lane);
    return SAMPLE_WIDTH'(r_lfsr[lane]);
  endfunction
`else
  function automatic logic [SAMPLE_WIDTH-1:0] f_sample(int lane);
    logic [SAMPLE_WIDTH-1:0] s;
    s = '0;
    s[SAMPLE_WIDTH-1 -: 3]  = 3'(lane);
    s[SAMPLE_WIDTH-4:0]     = r_count[SAMPLE_WIDTH-4:0];
    return s;
  endfunction
`endif

  always_comb begin
    w_state_n   = r_state;
    w_wait_n    = r_wait;
    w_bit_n     = r_bit;
    w_sdo_n     = r_sdo;
    w_count_n   = r_count;
    w_overrun_n = r_overrun;
    w_load      = 1'b0;
    for (int l = 0; l < N_LANES; l++) w_shreg_n[l] = r_shreg[l];

    if (!bus.i_enable) begin
      w_state_n = S_IDLE;
      w_sdo_n   = '0;
    end else if (r_cnv_fall) begin
      // a new strobe always (re)starts conversion, aborting any frame
      w_load    = 1'b1;
      w_count_n = r_count + 32'd1;
      w_wait_n  = WCW'(CONV_CYCLES - 1);
      w_sdo_n   = '0;
      w_state_n = S_CONV;
      if (r_state != S_IDLE) w_overrun_n = 1'b1;
      for (int l = 0; l < N_LANES; l++) w_shreg_n[l] = f_sample(l);
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_sdo_n = '0;
        end
        S_CONV: begin
          if (r_wait == '0) begin
            w_state_n = S_SHIFT;
            w_bit_n   = BCW'(SAMPLE_WIDTH - 1);
            for (int l = 0; l < N_LANES; l++)
              w_sdo_n[l] = r_shreg[l][SAMPLE_WIDTH-1];
          end else begin
            w_wait_n = r_wait - WCW'(1);
          end
        end
        S_SHIFT: begin
          if (r_sck_fall) begin
            if (r_bit != '0) begin
              w_bit_n = r_bit - BCW'(1);
              for (int l = 0; l < N_LANES; l++) begin
                w_sdo_n[l]   = r_shreg[l][SAMPLE_WIDTH-2];
                w_shreg_n[l] = r_shreg[l] << 1;
              end
            end else begin
              w_sdo_n   = '0;
              w_state_n = S_IDLE;
            end
          end
        end
        default: begin
          w_state_n = S_IDLE;
          w_sdo_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_wait    <= '0;
      r_bit     <= '0;
      r_sdo     <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
      for (int l = 0; l < N_LANES; l++) r_shreg[l] <= '0;
    end else begin
      r_state   <= w_state_n;
      r_wait    <= w_wait_n;
      r_bit     <= w_bit_n;
      r_sdo     <= w_sdo_n;
      r_count   <= w_count_n;
      r_overrun <= w_overrun_n;
      for (int l = 0; l < N_LANES; l++) r_shreg[l] <= w_shreg_n[l];
    end
  end

  assign bus.o_ADC_SDO    = r_sdo;
  assign bus.o_busy       = (r_state != S_IDLE);
  assign bus.o_conv_count = r_count;
  assign bus.o_overrun    = r_overrun;

endmodule
